// File: rtl/ccb_capture_mon.sv
// Ring-buffer capture of din around a trigger; window of DEPTH samples read out over valid/ready.
// First word within 2 cycles of done, then one per cycle; rd_data holds while rd_ready is low.
module ccb_capture_mon #(
   parameter int WIDTH = 51,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk40,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             arm,
   input  logic             abort,
   input  logic             force_trig,
   input  logic             trig_mode,
   input  logic [WIDTH-1:0] trig_mask,
   input  logic [WIDTH-1:0] trig_value,
   input  logic [AW-1:0]    pretrig,
   output logic             busy,
   output logic             triggered,
   output logic             done,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             rd_last
);
   typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] dat;
   } rd_ent_t;

   localparam logic [AW-1:0] MAX_PT   = AW'(DEPTH - 1);
   localparam logic [AW-1:0] AW_ONE   = AW'(1);
   localparam logic [AW:0]   N_WORDS  = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   LAST_IDX = (AW + 1)'(DEPTH - 1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

   state_t           state_q, state_d;
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    pt_q, pt_d;
   logic [AW-1:0]    tp_q, tp_d;
   logic             trig_q, trig_d;
   logic [WIDTH-1:0] din_dly_q, din_dly_d;
   logic [AW-1:0]    post_len;
   logic             we, hit, pop;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_dat_q;
   logic             ram_vld_q, ram_vld_d;
   logic             ram_last_q, ram_last_d;
   logic [AW:0]      iss_cnt_q, iss_cnt_d;
   logic [AW-1:0]    rd_addr;
   logic             issue;
   rd_ent_t          ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]       fcnt_q, fcnt_d, occ;

   assign post_len  = MAX_PT - pt_q;
   assign din_dly_d = din;
   assign busy      = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
   assign done      = (state_q == DONE);
   assign triggered = trig_q;
   assign rd_valid  = (fcnt_q != 2'd0);
   assign rd_data   = rd_valid ? ent0_q.dat : '0;
   assign rd_last   = rd_valid && ent0_q.last;
   assign pop       = rd_valid && rd_ready;

   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      cnt_d   = cnt_q;
      pt_d    = pt_q;
      tp_d    = tp_q;
      trig_d  = trig_q;
      we      = 1'b0;
      hit     = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm) begin
               state_d = PRE;
               pt_d    = pretrig;
               trig_d  = 1'b0;
               wp_d    = '0;
               cnt_d   = '0;
            end
         end
         PRE: begin
            if (pt_q == '0) begin
               state_d = ARMED;
            end else begin
               we    = 1'b1;
               wp_d  = wp_q + AW_ONE;
               cnt_d = cnt_q + AW_ONE;
               if (cnt_q + AW_ONE == pt_q) state_d = ARMED;
            end
         end
         ARMED: begin
            we   = 1'b1;
            wp_d = wp_q + AW_ONE;
            hit  = force_trig || (trig_mode ? (|((din ^ din_dly_q) & trig_mask))
                                            : ~(|((din ^ trig_value) & trig_mask)));
            if (hit) begin
               tp_d    = wp_q;
               trig_d  = 1'b1;
               cnt_d   = '0;
               state_d = (pt_q == MAX_PT) ? DONE : POST;
            end
         end
         POST: begin
            we    = 1'b1;
            wp_d  = wp_q + AW_ONE;
            cnt_d = cnt_q + AW_ONE;
            if (cnt_q + AW_ONE == post_len) state_d = DONE;
         end
         DONE: begin
            if (pop && rd_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         trig_d  = 1'b0;
         we      = 1'b0;
      end
   end

   // Reads issue only while the 2-entry buffer plus the word in flight has room.
   assign occ     = fcnt_q - {1'b0, pop} + {1'b0, ram_vld_q};
   assign issue   = (state_q == DONE) && (iss_cnt_q != N_WORDS) && (occ < 2'd2);
   assign rd_addr = tp_q - pt_q + iss_cnt_q[AW-1:0];

   always_comb begin
      ent0_d     = ent0_q;
      ent1_d     = ent1_q;
      fcnt_d     = fcnt_q;
      iss_cnt_d  = iss_cnt_q;
      ram_vld_d  = 1'b0;
      ram_last_d = 1'b0;
      if (pop) begin
         ent0_d = ent1_q;
         fcnt_d = fcnt_q - 2'd1;
      end
      if (ram_vld_q) begin
         if (fcnt_d == 2'd0) ent0_d = '{last: ram_last_q, dat: ram_dat_q};
         else                ent1_d = '{last: ram_last_q, dat: ram_dat_q};
         fcnt_d = fcnt_d + 2'd1;
      end
      if (issue) begin
         iss_cnt_d  = iss_cnt_q + CNT_ONE;
         ram_vld_d  = 1'b1;
         ram_last_d = (iss_cnt_q == LAST_IDX);
      end
      if (state_d != DONE) begin
         fcnt_d     = 2'd0;
         iss_cnt_d  = '0;
         ram_vld_d  = 1'b0;
         ram_last_d = 1'b0;
      end
   end

   always_ff @(posedge clk40) begin
      if (reset) begin
         state_q    <= IDLE;
         wp_q       <= '0;
         cnt_q      <= '0;
         pt_q       <= '0;
         tp_q       <= '0;
         trig_q     <= 1'b0;
         din_dly_q  <= '0;
         ram_vld_q  <= 1'b0;
         ram_last_q <= 1'b0;
         iss_cnt_q  <= '0;
         ent0_q     <= '0;
         ent1_q     <= '0;
         fcnt_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         wp_q       <= wp_d;
         cnt_q      <= cnt_d;
         pt_q       <= pt_d;
         tp_q       <= tp_d;
         trig_q     <= trig_d;
         din_dly_q  <= din_dly_d;
         ram_vld_q  <= ram_vld_d;
         ram_last_q <= ram_last_d;
         iss_cnt_q  <= iss_cnt_d;
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
         fcnt_q     <= fcnt_d;
      end
   end

   always_ff @(posedge clk40) begin
      if (we && !reset) mem[wp_q] <= din;
      if (issue)        ram_dat_q <= mem[rd_addr];
   end
endmodule

// File: doc/ccb_capture_mon.md
# ccb_capture_mon

Parametrised in-fabric capture monitor for the CCB receive bus, or any other wide synchronous bus. It records a configurable window of samples around a programmable trigger into an internal ring buffer, then streams the window out through a valid/ready read port. It sits beside the CCB receive logic in the clk40 domain, replacing the external logic-analyser core as the bring-up and debug tap, and adds pre-trigger depth, masked and change-detect trigger modes, and host-side readout.

## Interface
- WIDTH, 51, sampled bus width in bits
- DEPTH, 256, samples per capture; must be a power of 2 and at least 4
- AW, log2(DEPTH), address and count width (derived)
- clk40  in  1  sole clock; all logic is synchronous to its rising edge
- reset  in  1  synchronous, active-high reset
- din  in  WIDTH  bus sampled on every clock
- arm  in  1  one-cycle pulse; starts a capture (honoured in IDLE only)
- abort  in  1  returns to IDLE from any state next cycle; buffer contents become undefined
- force_trig  in  1  unconditional trigger (honoured in ARMED only)
- trig_mode  in  1  0 = pattern match, 1 = change detect
- trig_mask  in  WIDTH  bits that take part in the trigger
- trig_value  in  WIDTH  pattern compared in mode 0
- pretrig  in  AW  samples kept before the trigger; latched on arm
- busy  out  1  high in PRE, ARMED and POST
- triggered  out  1  high from the trigger cycle until the next arm or abort
- done  out  1  high in DONE
- rd_data  out  WIDTH  readout sample
- rd_valid  out  1  rd_data is valid
- rd_ready  in  1  consumer accepts; a transfer occurs when rd_valid and rd_ready are both high
- rd_last  out  1  qualifies the final transfer (index DEPTH-1)

## Operation
- States: IDLE, PRE, ARMED, POST, DONE. Reset forces IDLE.
- Reset values: every output 0; write pointer, counters and the latched pretrig are 0.
- IDLE → PRE when arm = 1.
  - Latches pretrig, clamped to DEPTH-1 when the input is larger.
  - Clears triggered.
  - Zeroes the write pointer and the pre-trigger count.
- Writing: in PRE, ARMED and POST, din is written to buffer[wp] every cycle, and wp increments modulo DEPTH. wp wraps freely in ARMED.
- PRE → ARMED once pretrig samples have been written. With pretrig = 0, PRE lasts exactly 1 cycle and writes nothing.
- Triggers are ignored in PRE.
- Trigger condition, evaluated in ARMED only:
  - Mode 0: ((din ^ trig_value) & trig_mask) == 0. An all-zero mask triggers on the first ARMED cycle.
  - Mode 1: ((din ^ din_q) & trig_mask) != 0, where din_q is din delayed by one cycle.
  - force_trig = 1 triggers in either mode.
- On trigger:
  - That cycle's din is written as the trigger sample, and its address is latched as tp.
  - triggered is set.
  - State goes to POST.
- POST writes DEPTH-1-pretrig further samples, then goes to DONE. With pretrig = DEPTH-1 there are zero further samples and the state goes directly to DONE.
- DONE (readout):
  - Read pointer starts at (tp - pretrig) mod DEPTH and advances modulo DEPTH on each transfer.
  - Exactly DEPTH transfers occur. The sample at readout index pretrig is the trigger sample.
  - After the transfer with rd_last, the next cycle returns to IDLE. done stays set until that point.
- Buffer: single-port write, registered read (block RAM style). The implementation prefetches so that rd_data stays stable while rd_valid is high and rd_ready is low.
- Simultaneous events:
  - abort beats every other input.
  - arm outside IDLE is ignored.
  - force_trig together with a mode 0/1 match gives a single trigger.

## Timing
- arm at cycle n: busy = 1 at n+1; the first write is din at n+1.
- Trigger at cycle t:
  - triggered = 1 at t+1.
  - The last POST write occurs at t + DEPTH-1-pretrig.
  - done = 1 and busy = 0 on the following cycle.
- First rd_valid appears no later than 2 cycles after done rises.
- With rd_ready held high, one transfer per cycle (no bubbles after the first word).
- rd_valid, once asserted, stays asserted until its transfer completes.
- abort at cycle n: IDLE, busy = 0, done = 0, rd_valid = 0 at n+1.
- reset mid-operation behaves as abort and also clears triggered.

## Test plan
- DEPTH=16, pretrig=4, din = cycle counter, mode 0, mask all-ones, trig_value = 100 → 16 words, 96..111, rd_last on 111, trigger word 100 at index 4.
- Mode 1, mask = bit 0 only, din toggles bit 0 at counter 50 (other bits vary freely) → trigger at 50; bit changes outside the mask never trigger.
- pretrig = 0 and pretrig = 15 (DEPTH-1) → readout starts at the trigger sample and ends at the trigger sample, respectively; an input of 31 clamps to 15.
- rd_ready driven by a random 50% pattern → readout sequence identical to the free-running case, with rd_data held stable while rd_valid = 1 and rd_ready = 0.
- Wrap: trigger after more than 3×DEPTH cycles in ARMED → correct window across the pointer wrap. force_trig in PRE is ignored; force_trig in ARMED triggers immediately.
- abort during POST, then reset during DONE mid-readout → IDLE next cycle with all outputs 0; a following arm captures correctly.
